// File: rtl/rgb_frame_feeder.sv
// Initiator for the rgb_to_gray converter: streams one frame of interleaved
// R,G,B bytes to the converter and stores each returned gray byte by pixel index.
module rgb_frame_feeder #(
  parameter int WIDTH   = 2048,
  parameter int HEIGHT  = 1153,
  parameter int ADDR_W  = 23,
  parameter int PIX_W   = 22,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rgb_rd_en,
  output logic [ADDR_W-1:0] rgb_rd_addr,
  input  logic [7:0]        rgb_rd_data,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              pix_valid,
  input  logic [7:0]        gray_in,
  input  logic              gray_done,
  output logic              gray_wr_en,
  output logic [PIX_W-1:0]  gray_wr_addr,
  output logic [7:0]        gray_wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_R, RD_G, RD_B, CAP_B, WAIT, WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d, gray_q, gray_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
  logic              frame_done_q, frame_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pix_q        <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      gray_q       <= '0;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pix_q        <= pix_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      gray_q       <= gray_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Read data lags its strobe by one cycle, so each channel lands one state later.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pix_d        = pix_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    gray_d       = gray_q;
    wd_d         = wd_q;
    timeout_d    = timeout_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !frame_done_q) begin
          state_d   = RD_R;
          addr_d    = '0;
          pix_d     = '0;
          timeout_d = 1'b0;
        end
      end
      RD_R: begin
        addr_d  = addr_q + 1'b1;
        state_d = RD_G;
      end
      RD_G: begin
        r_d     = rgb_rd_data;
        addr_d  = addr_q + 1'b1;
        state_d = RD_B;
      end
      RD_B: begin
        g_d     = rgb_rd_data;
        addr_d  = addr_q + 1'b1;
        state_d = CAP_B;
      end
      CAP_B: begin
        b_d     = rgb_rd_data;
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done strobe on the final allowed cycle still wins over the watchdog.
        if (gray_done) begin
          gray_d  = gray_in;
          state_d = WRITE;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WRITE: begin
        if (pix_q == LAST_PIX) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          pix_d   = pix_q + 1'b1;
          state_d = RD_R;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rgb_rd_en    = 1'b0;
    rgb_rd_addr  = '0;
    pix_valid    = 1'b0;
    gray_wr_en   = 1'b0;
    gray_wr_addr = '0;
    busy         = (state_q != IDLE);
    case (state_q)
      RD_R, RD_G, RD_B: begin
        rgb_rd_en   = 1'b1;
        rgb_rd_addr = addr_q;
      end
      WAIT:  pix_valid = 1'b1;
      WRITE: begin
        gray_wr_en   = 1'b1;
        gray_wr_addr = pix_q;
      end
      default: ;
    endcase
  end

  assign R            = r_q;
  assign G            = g_q;
  assign B            = b_q;
  assign gray_wr_data = gray_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_q;

endmodule
